// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo_ctrl FIFO family.
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Words between two wrap-bit pointers, taken modulo 2*DEPTH.
    function automatic int unsigned ptr_diff(input int unsigned wr_ptr,
                                             input int unsigned rd_ptr,
                                             input int unsigned addr_width);
        return (wr_ptr - rd_ptr) & ((32'd2 << addr_width) - 32'd1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read, no reset.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO with standard or first-word-fall-through read, occupancy and threshold flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flag registers.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH        = 8,
    parameter int DATA_WIDTH        = 8,
    parameter int FWFT              = 0,
    parameter int PROG_FULL_THRESH  = 2**ADDR_WIDTH - 4,
    parameter int PROG_EMPTY_THRESH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  prog_full,
    output logic                  prog_empty,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH     = 2**ADDR_WIDTH;
    localparam int                AF_INT    = DEPTH - 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_LVL    = AF_INT[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PF_LVL    = PROG_FULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PE_LVL    = PROG_EMPTY_THRESH[ADDR_WIDTH:0];
    localparam fifo_mode_e          MODE      = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  wr_acc, rd_acc, load_out, mem_avail;

    sync_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    // Status decodes from registered state only, so no input reaches an output combinationally.
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (MODE == FIFO_FWFT) ? ~rd_valid_q : (count_q == '0);
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= 1);
    assign prog_full    = (count_q >= PF_LVL);
    assign prog_empty   = (count_q <= PE_LVL);
    assign data_count   = count_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;

    // Handshake: a write takes effect on a clock edge when wr_en && !full, a read/pop when
    // rd_en && !empty; both use flag values from before that edge, and rejected requests are no-ops.
    always_comb begin
        mem_avail  = ptr_diff(32'(wr_ptr_q), 32'(rd_ptr_q), ADDR_WIDTH) != 32'd0;
        wr_acc     = wr_en && !full;
        rd_acc     = rd_en && !empty;
        load_out   = rd_acc;
        rd_valid_d = rd_acc;
        if (MODE == FIFO_FWFT) begin
            // Refill the output register when it is empty or being popped this cycle.
            load_out   = (!rd_valid_q || rd_acc) && mem_avail;
            rd_valid_d = load_out ? 1'b1 : (rd_acc ? 1'b0 : rd_valid_q);
        end

        wr_ptr_d  = wr_acc   ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = load_out ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_data_d = load_out ? mem_rdata : rd_data_q;

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (wr_en & full);
        underflow_d = underflow_q | (rd_en & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: one standard-mode and one FWFT instance, depth 16.
module tb_sync_fifo_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          s_wr_en, s_rd_en, f_wr_en, f_rd_en;
    logic [DW-1:0] s_wr_data, f_wr_data, s_rd_data, f_rd_data;
    logic          s_rd_valid, s_full, s_empty, s_af, s_ae, s_pf, s_pe, s_ovf, s_unf;
    logic          f_rd_valid, f_full, f_empty, f_af, f_ae, f_pf, f_pe, f_ovf, f_unf;
    logic [AW:0]   s_count, f_count;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] fexp_q[$];
    logic [DW-1:0] exp_word;

    sync_fifo_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0),
        .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(3)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .prog_full(s_pf), .prog_empty(s_pe),
        .data_count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1),
        .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(3)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .prog_full(f_pf), .prog_empty(f_pe),
        .data_count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected flags follow directly from the occupancy: depth 16, prog levels 12 / 3.
    task automatic chk_s_flags(input string tag, input int cnt);
        chk({tag, " s_count"}, 32'(s_count), cnt);
        chk({tag, " s_full"},  32'(s_full),  int'(cnt == 16));
        chk({tag, " s_empty"}, 32'(s_empty), int'(cnt == 0));
        chk({tag, " s_af"},    32'(s_af),    int'(cnt >= 15));
        chk({tag, " s_ae"},    32'(s_ae),    int'(cnt <= 1));
        chk({tag, " s_pf"},    32'(s_pf),    int'(cnt >= 12));
        chk({tag, " s_pe"},    32'(s_pe),    int'(cnt <= 3));
    endtask

    task automatic chk_f_flags(input string tag, input int cnt, input int valid);
        chk({tag, " f_count"}, 32'(f_count),    cnt);
        chk({tag, " f_valid"}, 32'(f_rd_valid), valid);
        chk({tag, " f_empty"}, 32'(f_empty),    int'(valid == 0));
        chk({tag, " f_full"},  32'(f_full),     int'(cnt == 16));
        chk({tag, " f_af"},    32'(f_af),       int'(cnt >= 15));
        chk({tag, " f_ae"},    32'(f_ae),       int'(cnt <= 1));
        chk({tag, " f_pf"},    32'(f_pf),       int'(cnt >= 12));
        chk({tag, " f_pe"},    32'(f_pe),       int'(cnt <= 3));
    endtask

    task automatic chk_reset_state(input string tag);
        chk_s_flags(tag, 0);
        chk({tag, " s_valid"}, 32'(s_rd_valid), 0);
        chk({tag, " s_data"},  32'(s_rd_data),  0);
        chk({tag, " s_ovf"},   32'(s_ovf),      0);
        chk({tag, " s_unf"},   32'(s_unf),      0);
        chk_f_flags(tag, 0, 0);
        chk({tag, " f_data"},  32'(f_rd_data),  0);
        chk({tag, " f_ovf"},   32'(f_ovf),      0);
        chk({tag, " f_unf"},   32'(f_unf),      0);
    endtask

    initial begin
        s_wr_en = 0; s_rd_en = 0; s_wr_data = '0;
        f_wr_en = 0; f_rd_en = 0; f_wr_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset and idle
        repeat (2) @(negedge clk);
        chk_reset_state("in_reset");
        rst_n = 1'b1;
        step();
        chk_reset_state("idle");

        // Standard mode: fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            s_wr_en = 1; s_wr_data = 8'(i);
            exp_q.push_back(8'(i));
            step();
            chk_s_flags("fill", i + 1);
            chk("fill s_valid", 32'(s_rd_valid), 0);
        end
        s_wr_data = 8'hEE;
        step();
        s_wr_en = 0;
        chk_s_flags("wr_full", 16);
        chk("wr_full s_ovf", 32'(s_ovf), ERR_EN);

        // Read 16 with idle gaps: one-cycle rd_valid pulse per read, data held between
        for (int i = 0; i < 16; i++) begin
            s_rd_en = 1;
            step();
            exp_word = exp_q.pop_front();
            chk("drain s_valid", 32'(s_rd_valid), 1);
            chk("drain s_data", 32'(s_rd_data), 32'(exp_word));
            chk_s_flags("drain", 15 - i);
            s_rd_en = 0;
            step();
            chk("gap s_valid", 32'(s_rd_valid), 0);
            chk("gap s_data", 32'(s_rd_data), 32'(exp_word));
        end

        // Standard read on empty
        s_rd_en = 1;
        step();
        s_rd_en = 0;
        chk_s_flags("s_rd_empty", 0);
        chk("s_rd_empty valid", 32'(s_rd_valid), 0);
        chk("s_rd_empty data", 32'(s_rd_data), 32'h0F);
        chk("s_rd_empty unf", 32'(s_unf), ERR_EN);
        chk("s_rd_empty ovf sticky", 32'(s_ovf), ERR_EN);

        // FWFT: word written at edge N appears after edge N+1
        f_wr_en = 1; f_wr_data = 8'hA5;
        fexp_q.push_back(8'hA5);
        step();
        f_wr_en = 0;
        chk_f_flags("fwft_n", 1, 0);
        step();
        chk_f_flags("fwft_n1", 1, 1);
        chk("fwft_n1 data", 32'(f_rd_data), 32'hA5);

        for (int i = 0; i < 7; i++) begin
            f_wr_en = 1; f_wr_data = 8'hB0 + 8'(i);
            fexp_q.push_back(8'hB0 + 8'(i));
            step();
            chk_f_flags("fwft_fill", 2 + i, 1);
            chk("fwft_fill head", 32'(f_rd_data), 32'hA5);
        end
        f_wr_en = 0;

        // Continuous pops stream one word per cycle
        f_rd_en = 1;
        for (int k = 0; k < 8; k++) begin
            exp_word = fexp_q.pop_front();
            chk("stream f_valid", 32'(f_rd_valid), 1);
            chk("stream f_data", 32'(f_rd_data), 32'(exp_word));
            step();
            chk("stream f_count", 32'(f_count), 7 - k);
        end
        f_rd_en = 0;
        chk_f_flags("fwft_drained", 0, 0);

        // FWFT read on empty
        f_rd_en = 1;
        step();
        f_rd_en = 0;
        chk_f_flags("f_rd_empty", 0, 0);
        chk("f_rd_empty unf", 32'(f_unf), ERR_EN);
        chk("f_rd_empty ovf", 32'(f_ovf), 0);

        // Half full, then 40 cycles of simultaneous write and read across pointer wrap
        for (int i = 0; i < 8; i++) begin
            s_wr_en = 1; s_wr_data = 8'h40 + 8'(i);
            f_wr_en = 1; f_wr_data = 8'h40 + 8'(i);
            exp_q.push_back(8'h40 + 8'(i));
            fexp_q.push_back(8'h40 + 8'(i));
            step();
        end
        s_wr_en = 0; f_wr_en = 0;
        step();
        chk_s_flags("half", 8);
        chk_f_flags("half", 8, 1);

        for (int j = 0; j < 40; j++) begin
            s_wr_en = 1; s_rd_en = 1; s_wr_data = 8'h80 + 8'(j);
            f_wr_en = 1; f_rd_en = 1; f_wr_data = 8'h80 + 8'(j);
            exp_word = fexp_q.pop_front();
            chk("sim f_valid", 32'(f_rd_valid), 1);
            chk("sim f_data", 32'(f_rd_data), 32'(exp_word));
            fexp_q.push_back(8'h80 + 8'(j));
            exp_q.push_back(8'h80 + 8'(j));
            step();
            exp_word = exp_q.pop_front();
            chk("sim s_valid", 32'(s_rd_valid), 1);
            chk("sim s_data", 32'(s_rd_data), 32'(exp_word));
            chk("sim s_count", 32'(s_count), 8);
            chk("sim f_count", 32'(f_count), 8);
        end
        s_wr_en = 0; s_rd_en = 0; f_wr_en = 0; f_rd_en = 0;
        step();

        // Asynchronous reset in the middle of a burst
        s_wr_en = 1; f_wr_en = 1; f_rd_en = 1;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("mid_reset");
        s_wr_en = 0; f_wr_en = 0; f_rd_en = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_reset_state("post_reset");

        // Normal operation after reset
        s_wr_en = 1; s_wr_data = 8'h3C;
        step();
        s_wr_en = 0; s_rd_en = 1;
        step();
        s_rd_en = 0;
        chk("post s_valid", 32'(s_rd_valid), 1);
        chk("post s_data", 32'(s_rd_data), 32'h3C);
        chk("post s_count", 32'(s_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
